// File: rtl/cube_slice_rx_pkg.sv
// Shared types for the cube slice link (receiver and future transmitter).
// A cube is [4:4][DIM-1:0][DIM-1:0][DIM-1:0], sent as DIM*DIM row beats.
package cube_slice_pkg;
  localparam int DIM   = 5;
  localparam int BEATS = DIM * DIM;
  localparam int CNT_W = 64;
  localparam int IDX_W = $clog2(BEATS);

  typedef logic [DIM-1:0] row_t;
  typedef logic [4:4][DIM-1:0][DIM-1:0][DIM-1:0] cube_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    FILL,
    HOLD
  } state_t;
endpackage

// File: rtl/cube_slice_rx_if.sv
// Slice-in / cube-out handshake bundle for cube_slice_rx.
// Optional x_seen present when CUBE_SLICE_RX_XCHECK_EN is defined.
interface cube_slice_rx_if;
  import cube_slice_pkg::*;

  logic  in_valid;
  logic  in_ready;
  row_t  in_data;
  logic  in_last;
  logic  out_valid;
  logic  out_ready;
  cube_t out_cube;
  cnt_t  out_frames;
  logic  err_framing;
`ifdef CUBE_SLICE_RX_XCHECK_EN
  logic  x_seen;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_cube, out_frames,
    input  err_framing, x_seen
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_cube, out_frames,
    output err_framing, x_seen
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_cube, out_frames,
    input  err_framing
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_cube, out_frames,
    output err_framing
  );
`endif
endinterface

// File: rtl/cube_beat_index.sv
// Beat index counter: wraps after BEATS-1, sync clear, last-beat flag.
// Shared between the slice receiver and transmitter.
module cube_beat_index
  import cube_slice_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output idx_t idx,
  output logic is_last
);

  assign is_last = (idx == idx_t'(BEATS - 1));

  // Clear wins over increment; increment wraps on the last beat.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= is_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/cube_slice_rx.sv
// Reassembles DIM-bit row slices into a packed cube, MSB-first.
// Define CUBE_SLICE_RX_XCHECK_EN to add the sticky x_seen flag.
module cube_slice_rx
  import cube_slice_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cube_slice_rx_if.slave bus
);

  state_t state;
  state_t state_nx;
  idx_t   idx;
  logic   is_last;
  logic   rdy;
  logic   vld;
  logic   take;
  logic   early;
  cube_t  cube;
  cnt_t   frames;
  logic   err;

  cube_beat_index u_idx (
    .clk     (clk),
    .rst     (rst),
    .clr     (early),
    .inc     (take),
    .idx     (idx),
    .is_last (is_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  // Handshake outputs and next state; HOLD exit and a new beat 0 may coincide.
  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    vld      = 1'b0;
    unique case (state)
      FILL: rdy = 1'b1;
      HOLD: begin
        vld = 1'b1;
        rdy = bus.out_ready;
      end
      default: ;
    endcase
    take  = bus.in_valid && rdy;
    early = take && bus.in_last && !is_last;
    if (vld && bus.out_ready) state_nx = FILL;
    if (take && is_last)      state_nx = HOLD;
  end

  // Cube storage, frame counter and sticky framing error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cube   <= '0;
      frames <= '0;
      err    <= 1'b0;
    end else begin
      if (vld && bus.out_ready) frames <= frames + 1'b1;
      if (early || (take && is_last && !bus.in_last)) err <= 1'b1;
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (take && idx == idx_t'(r * DIM + c))
            cube[4][DIM-1-r][DIM-1-c] <= bus.in_data;
        end
      end
    end
  end

  assign bus.in_ready    = rdy;
  assign bus.out_valid   = vld;
  assign bus.out_cube    = cube;
  assign bus.out_frames  = frames;
  assign bus.err_framing = err;

`ifdef CUBE_SLICE_RX_XCHECK_EN
  logic xs;

  // Sticky flag for any unknown bit on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst)
      xs <= 1'b0;
    else if (take && ((^bus.in_data) === 1'bx))
      xs <= 1'b1;
  end

  assign bus.x_seen = xs;
`endif

endmodule

// File: tb/tb_cube_slice_rx.sv
// Bench for cube_slice_rx: directed cases plus random traffic
// against a beat-list reference model of the cube link.
module tb_cube_slice_rx;
  import cube_slice_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cube_slice_rx_if bus ();

  cube_slice_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  bit          m_hold;
  int          m_cnt;
  cube_t       m_cube;
  longint unsigned m_frames;
  bit          m_err;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: beats fill the cube in arrival order, MSB row/bit first.
  always @(posedge clk) begin
    bit r;
    bit t;
    if (rst) begin
      m_hold   = 1'b0;
      m_cnt    = 0;
      m_cube   = '0;
      m_frames = 0;
      m_err    = 1'b0;
    end else begin
      r = !m_hold || bus.out_ready;
      t = bus.in_valid && r;
      if (m_hold && bus.out_ready) begin
        m_frames++;
        m_hold = 1'b0;
      end
      if (t) begin
        m_cube[4][DIM-1-m_cnt/DIM][DIM-1-m_cnt%DIM] = bus.in_data;
        if (m_cnt == BEATS - 1) begin
          m_hold = 1'b1;
          m_cnt  = 0;
          if (!bus.in_last) m_err = 1'b1;
        end else if (bus.in_last) begin
          m_err = 1'b1;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 128'(bus.in_ready), 128'(!m_hold || bus.out_ready));
      chk("out_valid", 128'(bus.out_valid), 128'(m_hold));
      chk("out_frames", 128'(bus.out_frames), 128'(m_frames));
      chk("err_framing", 128'(bus.err_framing), 128'(m_err));
      if (m_hold) chk("out_cube", 128'(bus.out_cube), 128'(m_cube));
    end
  end

  task automatic drive(bit v, row_t d, bit l, bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(row_t d, bit l, bit r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = r;
      #2;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: got in_ready=0 want 1");
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic send_cube(int base, bit last_ok, bit r);
    for (int k = 0; k < BEATS; k++)
      beat(row_t'(k + base), (k == BEATS - 1) ? last_ok : 1'b0, r);
  endtask

  initial begin
    cube_t cv;
    bit v;
    bit l;
    bit r;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    do_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_frames", 128'(bus.out_frames), 128'(0));
    chk("rst_cube", 128'(bus.out_cube), 128'(0));
    chk("rst_err", 128'(bus.err_framing), 128'(0));

    send_cube(0, 1'b1, 1'b0);
    chk("lat_valid", 128'(bus.out_valid), 128'(1));
    cv = bus.out_cube;
    chk("cube_444", 128'(cv[4][4][4]), 128'(0));
    chk("cube_400", 128'(cv[4][0][0]), 128'(24));
    chk("cube_423", 128'(cv[4][2][3]), 128'(11));
    for (int i = 0; i < 10; i++) drive(1'b0, '0, 1'b0, 1'b0);
    chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
    chk("hold_cube", 128'(bus.out_cube), 128'(cv));
    beat(row_t'(0), 1'b0, 1'b1);
    chk("exit_frames", 128'(bus.out_frames), 128'(1));
    chk("exit_valid", 128'(bus.out_valid), 128'(0));
    for (int k = 1; k < BEATS; k++)
      beat(row_t'(k + 2), k == BEATS - 1, 1'b1);
    chk("second_valid", 128'(bus.out_valid), 128'(1));
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("second_frames", 128'(bus.out_frames), 128'(2));

    for (int k = 0; k < 8; k++) beat(row_t'(k + 20), k == 7, 1'b1);
    chk("early_err", 128'(bus.err_framing), 128'(1));
    chk("early_valid", 128'(bus.out_valid), 128'(0));
    send_cube(3, 1'b1, 1'b0);
    chk("after_err_valid", 128'(bus.out_valid), 128'(1));
    chk("after_err_444", 128'(bus.out_cube[4][4][4]), 128'(3));
    chk("err_sticky", 128'(bus.err_framing), 128'(1));
    drive(1'b0, '0, 1'b0, 1'b1);

    do_reset();
    send_cube(7, 1'b0, 1'b0);
    chk("nolast_valid", 128'(bus.out_valid), 128'(1));
    chk("nolast_err", 128'(bus.err_framing), 128'(1));
    drive(1'b0, '0, 1'b0, 1'b1);

    do_reset();
    for (int k = 0; k < 12; k++) beat(row_t'(k + 1), 1'b0, 1'b1);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("mid_rst_ready", 128'(bus.in_ready), 128'(1));
    chk("mid_rst_valid", 128'(bus.out_valid), 128'(0));
    chk("mid_rst_cube", 128'(bus.out_cube), 128'(0));
    chk("mid_rst_frames", 128'(bus.out_frames), 128'(0));
    rst = 1'b0;
    send_cube(9, 1'b1, 1'b0);
    chk("fresh_444", 128'(bus.out_cube[4][4][4]), 128'(9));
    chk("fresh_err", 128'(bus.err_framing), 128'(0));
    drive(1'b0, '0, 1'b0, 1'b1);

`ifdef CUBE_SLICE_RX_XCHECK_EN
    do_reset();
    chk("x_rst", 128'(bus.x_seen), 128'(0));
    for (int k = 0; k < BEATS; k++)
      beat((k == 3) ? 5'b0x100 : row_t'(k), k == BEATS - 1, 1'b0);
    chk("x_seen", 128'(bus.x_seen), 128'(1));
    chk("x_cube", 128'(bus.out_cube[4][4][1]), 128'(5'b0x100));
    drive(1'b0, '0, 1'b0, 1'b1);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 4) != 0;
      r = ($urandom % 3) != 0;
      if (m_cnt == BEATS - 1) l = ($urandom % 16) != 0;
      else                    l = ($urandom % 40) == 0;
      drive(v, row_t'($urandom), l, r);
    end
    drive(1'b0, '0, 1'b0, 1'b1);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
